// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences each instruction through FETCH/EXEC/MEM/WB
// and drives datapath selects from the latched opcode, with IN/OUT/HALT handshakes.
module multicycle_control_unit #(
    parameter int OPCODE_W   = 6,
    parameter int ALU_W      = 4,
    parameter int PCSEL_W    = 3,
    parameter int IN_TIMEOUT = 0,
    parameter int TO_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ready,
    input  logic                disp_ack,
    input  logic                resume,
    output logic                ir_load,
    output logic                pc_en,
    output logic                sreg,
    output logic                smux5,
    output logic                smux32,
    output logic [1:0]          smux16,
    output logic [PCSEL_W-1:0]  smuxPC,
    output logic [ALU_W-1:0]    salu,
    output logic                smem,
    output logic                smemtoreg,
    output logic                sdisplay,
    output logic                in_ack,
    output logic                halt,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH, S_EXEC, S_MEM, S_WB, S_IN_WAIT, S_OUT_WAIT, S_HALT, S_TRAP
    } state_t;

    localparam logic [5:0] OP_HALT  = 6'h15;
    localparam logic [5:0] OP_IN    = 6'h16;
    localparam logic [5:0] OP_OUT   = 6'h17;
    localparam logic [5:0] OP_LOAD  = 6'h18;
    localparam logic [5:0] OP_STORE = 6'h1D;

    state_t          state, nxt;
    logic [5:0]      op_q;
    logic [TO_W-1:0] cnt;
    logic            trap_q;
    logic [1:0]      cause_q;
    logic            timeout;
    logic [3:0]      alu4;
    logic [2:0]      pc3;

    // Only 0x00..0x1D are defined; any set bit above bit 5 is illegal.
    function automatic logic legal(input logic [OPCODE_W-1:0] op);
        return ((op >> 6) == '0) && (op[5:0] <= 6'h1D);
    endfunction

    assign timeout = (IN_TIMEOUT != 0) && (cnt == TO_W'(IN_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH: begin
                if (!legal(opcode))              nxt = S_TRAP;
                else if (opcode[5:0] == OP_IN)   nxt = S_IN_WAIT;
                else if (opcode[5:0] == OP_OUT)  nxt = S_OUT_WAIT;
                else if (opcode[5:0] == OP_HALT) nxt = S_HALT;
                else                             nxt = S_EXEC;
            end
            S_EXEC:     nxt = (op_q == OP_LOAD || op_q == OP_STORE) ? S_MEM : S_FETCH;
            S_MEM:      nxt = (op_q == OP_LOAD) ? S_WB : S_FETCH;
            S_WB:       nxt = S_FETCH;
            S_IN_WAIT: begin
                if (ready)        nxt = S_WB;
                else if (timeout) nxt = S_TRAP;
            end
            S_OUT_WAIT: if (disp_ack) nxt = S_FETCH;
            S_HALT:     if (resume)   nxt = S_FETCH;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_FETCH;
        endcase
    end

    // Opcode latch, IN wait counter and sticky trap record.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            cnt     <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            if (state == S_FETCH) op_q <= opcode[5:0];
            cnt <= (state == S_IN_WAIT && !ready) ? cnt + TO_W'(1) : '0;
            if (state != S_TRAP && nxt == S_TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= (state == S_IN_WAIT) ? 2'b10 : 2'b01;
            end
        end
    end

    always_comb begin
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        sreg       = 1'b0;
        smux5      = 1'b0;
        smux32     = 1'b0;
        smux16     = 2'b00;
        smem       = 1'b0;
        smemtoreg  = 1'b0;
        sdisplay   = 1'b0;
        in_ack     = 1'b0;
        halt       = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'b00;
        alu4       = 4'h0;
        pc3        = 3'd0;
        // While reset is held every output reads 0, including the trap record.
        if (!reset) begin
            trap       = trap_q;
            trap_cause = cause_q;
            case (state)
                S_FETCH: ir_load = 1'b1;
                S_EXEC: begin
                    pc_en  = 1'b1;
                    sreg   = op_q inside {[6'h01:6'h10], [6'h19:6'h1C]};
                    smux5  = op_q inside {6'h02, 6'h05, 6'h19, 6'h1A};
                    smux32 = smux5;
                    if (op_q == 6'h1A) smux16 = 2'b01;
                    case (op_q)
                        6'h03: alu4 = 4'h2;
                        6'h04, 6'h05, 6'h11, 6'h12: alu4 = 4'h1;
                        6'h06: alu4 = 4'h3;
                        6'h07: alu4 = 4'h4;
                        6'h08: alu4 = 4'h5;
                        6'h09: alu4 = 4'h6;
                        6'h0A: alu4 = 4'h7;
                        6'h0B: alu4 = 4'hF;
                        6'h0C: alu4 = 4'h8;
                        6'h0D: alu4 = 4'h9;
                        6'h0E: alu4 = 4'hA;
                        6'h0F: alu4 = 4'hC;
                        6'h10: alu4 = 4'hB;
                        6'h1B: alu4 = 4'hD;
                        6'h1C: alu4 = 4'hE;
                        default: alu4 = 4'h0;
                    endcase
                    case (op_q)
                        6'h11:   pc3 = 3'd1;
                        6'h12:   pc3 = 3'd2;
                        6'h13:   pc3 = 3'd3;
                        6'h14:   pc3 = 3'd4;
                        default: pc3 = 3'd0;
                    endcase
                end
                S_MEM: begin
                    smux5  = 1'b1;
                    smux32 = 1'b1;
                    smem   = (op_q == OP_STORE);
                end
                S_WB: begin
                    sreg   = 1'b1;
                    smux5  = 1'b1;
                    smux32 = 1'b1;
                    if (op_q == OP_IN) begin
                        smux16 = 2'b10;
                        in_ack = 1'b1;
                    end else begin
                        smemtoreg = 1'b1;
                    end
                end
                S_IN_WAIT:  halt = !ready;
                S_OUT_WAIT: begin
                    sdisplay = 1'b1;
                    pc_en    = disp_ack;
                end
                S_HALT: begin
                    halt  = !resume;
                    pc_en = resume;
                end
                S_TRAP:  halt = 1'b1;
                default: ;
            endcase
        end
    end

    assign salu   = ALU_W'(alu4);
    assign smuxPC = PCSEL_W'(pc3);

endmodule
